// File: rtl/onehot_encoder_seq_if.sv
// Handshake bundle for onehot_encoder_seq: request-vector input
// side and 5-bit code output side, with drain status.
interface onehot_encoder_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vec;
    logic        code_valid;
    logic        code_ready;
    logic [4:0]  code;
    logic        code_last;
    logic        done;
    logic [5:0]  count;

    modport master (
        output req_valid, req_vec, code_ready,
        input  req_ready, code_valid, code, code_last, done, count
    );

    modport slave (
        input  req_valid, req_vec, code_ready,
        output req_ready, code_valid, code, code_last, done, count
    );
endinterface

// File: rtl/onehot_encoder_seq.sv
// Sequential 32-bit vector to 5-bit index encoder: emits the index
// of each set bit, lowest first, one per handshake, then pulses done.
module onehot_encoder_seq (
    input  logic                 clk,
    input  logic                 reset,
    onehot_encoder_seq_if.slave  bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [5:0]  count_q, count_d;

    logic [4:0]  low_idx;
    logic [31:0] low_mask;
    logic        single;

    // Lowest set bit of pending and whether it is the only one left.
    always_comb begin
        low_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (pending_q[i]) low_idx = 5'(i);
        end
        low_mask = 32'd1 << low_idx;
        single   = (pending_q != 32'd0) &&
                   ((pending_q & (pending_q - 32'd1)) == 32'd0);
    end

    // Next-state, pending/count update and handshake outputs.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        count_d        = count_q;
        bus.req_ready  = 1'b0;
        bus.code_valid = 1'b0;
        bus.code       = 5'd0;
        bus.code_last  = 1'b0;
        bus.done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    pending_d = bus.req_vec;
                    count_d   = 6'd0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (pending_q != 32'd0) begin
                    bus.code_valid = 1'b1;
                    bus.code       = low_idx;
                    bus.code_last  = single;
                    if (bus.code_ready) begin
                        pending_d = pending_q & ~low_mask;
                        count_d   = count_q + 6'd1;
                    end
                end else begin
                    bus.done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.count = count_q;

    // State, pending vector and emitted-code count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 32'd0;
            count_q   <= 6'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Scoreboard bench for onehot_encoder_seq: directed vectors push
// expected codes, done counts and cycle-stamped signal values.
module tb_onehot_encoder_seq;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    logic fin = 1'b0;

    onehot_encoder_seq_if bus ();

    onehot_encoder_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam int S_RDY  = 0;
    localparam int S_VAL  = 1;
    localparam int S_CODE = 2;
    localparam int S_LAST = 3;
    localparam int S_DONE = 4;
    localparam int S_CNT  = 5;

    typedef struct {
        int          c;
        int          sel;
        logic [31:0] exp;
        string       name;
    } tchk_t;

    tchk_t      tq[$];
    logic [5:0] cq[$];
    logic [5:0] dq[$];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    // Cycle stamp used to schedule timed expectations.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sig(input int sel);
        case (sel)
            S_RDY:   return 32'(bus.req_ready);
            S_VAL:   return 32'(bus.code_valid);
            S_CODE:  return 32'(bus.code);
            S_LAST:  return 32'(bus.code_last);
            S_DONE:  return 32'(bus.done);
            default: return 32'(bus.count);
        endcase
    endfunction

    task automatic tc(input int k, input int off, input int sel,
                      input logic [31:0] e, input string nm);
        tq.push_back('{k + off, sel, e, nm});
    endtask

    task automatic accept(input logic [31:0] v, output int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            $display("FAIL accept_timeout req_ready=%0b required=1",
                     bus.req_ready);
            $fatal(1);
        end
        bus.req_valid = 1'b1;
        bus.req_vec   = v;
        @(posedge clk);
        #1;
        k = cyc;
        bus.req_valid = 1'b0;
        bus.req_vec   = 32'd0;
    endtask

    // Stimulus: directed vectors with hand-computed expectations.
    initial begin
        int k;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_vec    = 32'd0;
        bus.code_ready = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        tc(k, 0, S_RDY, 1, "rst_ready");
        tc(k, 0, S_VAL, 0, "rst_valid");
        tc(k, 0, S_CODE, 0, "rst_code");
        tc(k, 0, S_LAST, 0, "rst_last");
        tc(k, 0, S_DONE, 0, "rst_done");
        tc(k, 0, S_CNT, 0, "rst_count");
        @(posedge clk);
        #1;
        reset = 1'b0;

        cq.push_back({5'd0, 1'b1});
        dq.push_back(6'd1);
        accept(32'h0000_0001, k);
        tc(k, 0, S_VAL, 1, "v1_valid");
        tc(k, 0, S_CODE, 0, "v1_code");
        tc(k, 0, S_LAST, 1, "v1_last");
        tc(k, 0, S_RDY, 0, "v1_busy");
        tc(k, 1, S_DONE, 1, "v1_done");
        tc(k, 1, S_VAL, 0, "v1_done_novalid");
        tc(k, 1, S_CNT, 1, "v1_count");
        tc(k, 1, S_RDY, 0, "v1_done_busy");
        tc(k, 2, S_RDY, 1, "v1_ready_back");
        tc(k, 2, S_CNT, 1, "v1_count_held");

        cq.push_back({5'd2, 1'b0});
        cq.push_back({5'd4, 1'b0});
        cq.push_back({5'd31, 1'b1});
        dq.push_back(6'd3);
        accept(32'h8000_0014, k);
        tc(k, 0, S_CODE, 2, "v3_code0");
        tc(k, 1, S_CODE, 4, "v3_code1");
        tc(k, 1, S_CNT, 1, "v3_cnt1");
        tc(k, 2, S_CODE, 31, "v3_code2");
        tc(k, 2, S_LAST, 1, "v3_last");
        tc(k, 2, S_CNT, 2, "v3_cnt2");
        tc(k, 3, S_DONE, 1, "v3_done");
        tc(k, 4, S_RDY, 1, "v3_ready");

        for (int i = 0; i < 32; i++) cq.push_back({5'(i), i == 31});
        dq.push_back(6'd32);
        accept(32'hFFFF_FFFF, k);
        tc(k, 0, S_LAST, 0, "ff_first_notlast");
        tc(k, 31, S_CODE, 31, "ff_code31");
        tc(k, 31, S_LAST, 1, "ff_last");
        tc(k, 32, S_DONE, 1, "ff_done");
        tc(k, 32, S_CNT, 32, "ff_count");
        tc(k, 32, S_RDY, 0, "ff_done_busy");
        tc(k, 33, S_RDY, 1, "ff_ready");
        tc(k, 33, S_CNT, 32, "ff_count_held");

        dq.push_back(6'd0);
        accept(32'h0, k);
        tc(k, 0, S_DONE, 1, "zero_done");
        tc(k, 0, S_VAL, 0, "zero_novalid");
        tc(k, 0, S_CNT, 0, "zero_count");
        tc(k, 0, S_RDY, 0, "zero_busy");
        tc(k, 1, S_RDY, 1, "zero_ready");
        tc(k, 1, S_DONE, 0, "zero_done_pulse");

        cq.push_back({5'd8, 1'b0});
        cq.push_back({5'd9, 1'b1});
        dq.push_back(6'd2);
        bus.code_ready = 1'b0;
        accept(32'h0000_0300, k);
        tc(k, 0, S_CODE, 8, "bp_code_c0");
        tc(k, 0, S_VAL, 1, "bp_valid_c0");
        tc(k, 1, S_RDY, 0, "bp_ignore_req");
        tc(k, 2, S_CODE, 8, "bp_code_c2");
        tc(k, 2, S_CNT, 0, "bp_count_stall");
        tc(k, 3, S_CODE, 8, "bp_code_c3");
        tc(k, 4, S_CODE, 9, "bp_code_c4");
        tc(k, 4, S_LAST, 1, "bp_last");
        tc(k, 5, S_DONE, 1, "bp_done");
        tc(k, 6, S_RDY, 1, "bp_ready");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid = (i == 0);
            bus.req_vec   = (i == 0) ? 32'hFFFF_FFFF : 32'd0;
        end
        bus.code_ready = 1'b1;

        cq.push_back({5'd4, 1'b0});
        accept(32'h0000_00F0, k);
        tc(k, 0, S_CODE, 4, "rs_code");
        tc(k, 1, S_CNT, 1, "rs_count_pre");
        tc(k, 1, S_CODE, 5, "rs_code_next");
        tc(k, 2, S_RDY, 1, "rs_idle");
        tc(k, 2, S_VAL, 0, "rs_novalid");
        tc(k, 2, S_CODE, 0, "rs_code_zero");
        tc(k, 2, S_CNT, 0, "rs_count_zero");
        tc(k, 2, S_DONE, 0, "rs_no_done");
        @(posedge clk);
        #1;
        bus.code_ready = 1'b0;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.code_ready = 1'b1;

        cq.push_back({5'd1, 1'b1});
        dq.push_back(6'd1);
        accept(32'h0000_0002, k);
        tc(k, 0, S_CODE, 1, "post_code");
        tc(k, 1, S_DONE, 1, "post_done");
        tc(k, 2, S_RDY, 1, "post_ready");

        repeat (5) @(posedge clk);
        #1;
        fin = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] e);
        total++;
        if (act === e) pass_cnt++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, e);
    endtask

    logic       stall_prev = 1'b0;
    logic [4:0] held_code;
    logic       held_last;

    // Monitor: scoreboard pops, timed checks and stall stability.
    always @(negedge clk) begin
        for (int i = tq.size() - 1; i >= 0; i--) begin
            if (tq[i].c == cyc) begin
                chk(tq[i].name, sig(tq[i].sel), tq[i].exp);
                tq.delete(i);
            end
        end
        if (stall_prev) begin
            chk("stall_hold", {bus.code_valid, bus.code, bus.code_last},
                {1'b1, held_code, held_last});
        end
        if (bus.code_valid && bus.code_ready) begin
            if (cq.size() == 0) begin
                chk("code_unexpected", {bus.code, bus.code_last}, 6'h3f);
            end else begin
                chk("code_stream", {bus.code, bus.code_last},
                    cq.pop_front());
            end
        end
        if (bus.done) begin
            chk("done_no_overlap", 32'(bus.code_valid), 0);
            if (dq.size() == 0) begin
                chk("done_unexpected", 32'(bus.count), 32'hFF);
            end else begin
                chk("done_count", 32'(bus.count), 32'(dq.pop_front()));
            end
        end
        stall_prev = bus.code_valid && !bus.code_ready && !reset;
        held_code  = bus.code;
        held_last  = bus.code_last;
        if (cyc > 5000) begin
            $display("FAIL watchdog cycles=%0d required<=5000", cyc);
            $fatal(1);
        end
        if (fin) begin
            chk("codes_drained", 32'(cq.size()), 0);
            chk("dones_drained", 32'(dq.size()), 0);
            chk("timed_drained", 32'(tq.size()), 0);
            $display("%0d/%0d checks passed", pass_cnt, total);
            $finish;
        end
    end
endmodule
